// File: rtl/conv_pkg.sv
// Shared widths, tap-count helpers and signed data types for the convolution
// window MAC engine and its weight bank.
package conv_pkg;

  localparam int DEF_DATA_W = 18;
  localparam int DEF_COEF_W = 18;
  localparam int DEF_ACC_W  = 48;
  localparam int DEF_K      = 3;
  localparam int DEF_C      = 3;

  function automatic int n_taps(input int k, input int c);
    return k * k * c;
  endfunction

  // Width of a tap index; at least one bit so degenerate windows still elaborate.
  function automatic int tap_width(input int k, input int c);
    int n;
    n = k * k * c;
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_N_TAPS = n_taps(DEF_K, DEF_C);
  localparam int TAP_W      = tap_width(DEF_K, DEF_C);

  typedef logic signed [DEF_DATA_W-1:0] pixel_t;
  typedef logic signed [DEF_COEF_W-1:0] coef_t;
  typedef logic signed [DEF_ACC_W-1:0]  acc_t;
  typedef logic [TAP_W-1:0]             tap_t;

endpackage

// File: rtl/conv_weight_bank.sv
// N-entry weight register file: one synchronous write port, one combinational
// read port addressed by the running tap index.
module conv_weight_bank
  import conv_pkg::*;
#(
  parameter int N_TAPS = DEF_N_TAPS,
  parameter int COEF_W = DEF_COEF_W,
  parameter int ADDR_W = TAP_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [COEF_W-1:0] wr_data_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [COEF_W-1:0] rd_data_o
);

  logic [COEF_W-1:0] mem_q [N_TAPS];

  // NOTE: the weights must come out of reset as zero, so this register file
  // carries a reset; a plain storage array would normally be left unreset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_TAPS; i++) mem_q[i] <= '0;
    end else if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/conv_window_macc.sv
// Streaming K x K x C window multiply-accumulate: one registered product stage,
// one accumulate stage, and a held valid/ready output register per window.
module conv_window_macc
  import conv_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int COEF_W = DEF_COEF_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int K      = DEF_K,
  parameter int C      = DEF_C,
  parameter int RELU   = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         w_wr_en,
  input  logic [tap_width(K, C)-1:0]   w_wr_addr,
  input  logic [COEF_W-1:0]            w_wr_data,
  output logic                         w_wr_err,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_W-1:0]            in_pixel,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [ACC_W-1:0]             out_activation,
  output logic                         busy
);

  localparam int N_TAP  = n_taps(K, C);
  localparam int TW     = tap_width(K, C);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam logic [TW-1:0] LAST_TAP = TW'(N_TAP - 1);

  logic [TW-1:0]              tap_q, tap_d;
  logic                       s1_valid_q, s1_valid_d;
  logic                       s1_first_q, s1_first_d;
  logic                       s1_last_q, s1_last_d;
  logic signed [PROD_W-1:0]   s1_prod_q, s1_prod_d;
  logic                       s2_valid_q, s2_valid_d;
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic                       out_valid_q, out_valid_d;
  logic signed [ACC_W-1:0]    out_q, out_d;
  logic                       w_wr_err_q, w_wr_err_d;

  logic                       in_hs, s2_take, w_accept;
  logic [COEF_W-1:0]          w_rd;
  logic signed [ACC_W-1:0]    prod_ext, acc_sum, result;

  assign in_ready = !(out_valid_q && !out_ready) && !clear;
  assign in_hs    = in_valid && in_ready;
  assign busy     = (tap_q != '0) || s1_valid_q || s2_valid_q;

  // Out-of-range addresses are refused as well, so the bank is never indexed past N-1.
  assign w_accept = w_wr_en && !busy && !in_hs && (w_wr_addr <= LAST_TAP);

  conv_weight_bank #(
    .N_TAPS (N_TAP),
    .COEF_W (COEF_W),
    .ADDR_W (TW)
  ) u_weight_bank (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (w_accept),
    .wr_addr_i (w_wr_addr),
    .wr_data_i (w_wr_data),
    .rd_addr_i (tap_q),
    .rd_data_o (w_rd)
  );

  // Stage 2 math; a clear in the same cycle discards the in-flight product.
  assign s2_take  = s1_valid_q && !clear;
  assign prod_ext = ACC_W'(s1_prod_q);
  assign acc_sum  = s1_first_q ? prod_ext : acc_q + prod_ext;
  assign result   = ((RELU != 0) && acc_sum[ACC_W-1]) ? '0 : acc_sum;

  // NOTE: every _d gets its hold value first, so no path through this block
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    tap_d       = tap_q;
    s1_valid_d  = in_hs;
    s1_first_d  = s1_first_q;
    s1_last_d   = s1_last_q;
    s1_prod_d   = s1_prod_q;
    s2_valid_d  = s2_take;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_d       = out_q;
    w_wr_err_d  = w_wr_en && !w_accept;

    if (clear) begin
      tap_d = '0;
    end else if (in_hs) begin
      tap_d = (tap_q == LAST_TAP) ? '0 : tap_q + TW'(1);
    end

    if (in_hs) begin
      s1_first_d = (tap_q == '0);
      s1_last_d  = (tap_q == LAST_TAP);
      s1_prod_d  = PROD_W'($signed(in_pixel)) * PROD_W'($signed(w_rd));
    end

    if (clear) begin
      acc_d = '0;
    end else if (s2_take) begin
      acc_d = acc_sum;
    end

    // A result arriving during an output handshake simply replaces the old one.
    if (s2_take && s1_last_q) begin
      out_valid_d = 1'b1;
      out_d       = result;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tap_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_first_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_prod_q   <= '0;
      s2_valid_q  <= 1'b0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      w_wr_err_q  <= 1'b0;
    end else begin
      tap_q       <= tap_d;
      s1_valid_q  <= s1_valid_d;
      s1_first_q  <= s1_first_d;
      s1_last_q   <= s1_last_d;
      s1_prod_q   <= s1_prod_d;
      s2_valid_q  <= s2_valid_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      w_wr_err_q  <= w_wr_err_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign out_activation = out_q;
  assign w_wr_err       = w_wr_err_q;

endmodule

// File: tb/tb_conv_window_macc.sv
// Directed and randomized checks of conv_window_macc (plain and RELU builds)
// against a dot-product reference model of the weight set.
module tb_conv_window_macc;

  localparam int N = 27;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic        w_wr_en = 1'b0;
  logic [4:0]  w_wr_addr = '0;
  logic [17:0] w_wr_data = '0;
  logic        in_valid = 1'b0;
  logic [17:0] in_pixel = '0;
  logic        out_ready = 1'b1;

  logic        w_wr_err, in_ready, out_valid, busy;
  logic [47:0] out_activation;
  logic        w_wr_err_r, in_ready_r, out_valid_r, busy_r;
  logic [47:0] out_activation_r;

  conv_window_macc #(.RELU(0)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .w_wr_en(w_wr_en), .w_wr_addr(w_wr_addr), .w_wr_data(w_wr_data), .w_wr_err(w_wr_err),
    .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
    .out_valid(out_valid), .out_ready(out_ready), .out_activation(out_activation),
    .busy(busy)
  );

  conv_window_macc #(.RELU(1)) dut_relu (
    .clk(clk), .rst(rst), .clear(clear),
    .w_wr_en(w_wr_en), .w_wr_addr(w_wr_addr), .w_wr_data(w_wr_data), .w_wr_err(w_wr_err_r),
    .in_valid(in_valid), .in_ready(in_ready_r), .in_pixel(in_pixel),
    .out_valid(out_valid_r), .out_ready(out_ready), .out_activation(out_activation_r),
    .busy(busy_r)
  );

  always #5 clk = ~clk;

  int     n_asserts = 0;
  int     n_fail = 0;
  longint cyc = 0;
  longint res_q[$], res_r_q[$], res_cyc_q[$], hs_cyc_q[$];
  longint w_model[N];

  function automatic longint sx(input logic [47:0] v);
    return longint'($signed(v));
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Handshakes are observed mid-cycle; they complete at the following rising edge.
  always @(negedge clk) begin
    if (rst && in_valid && in_ready) hs_cyc_q.push_back(cyc);
    if (rst && out_valid && out_ready) begin
      res_q.push_back(sx(out_activation));
      res_cyc_q.push_back(cyc);
    end
    if (rst && out_valid_r && out_ready) res_r_q.push_back(sx(out_activation_r));
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint model(input int pix[N], input bit relu);
    longint s = 0;
    for (int i = 0; i < N; i++) s += longint'(pix[i]) * w_model[i];
    if (relu && s < 0) s = 0;
    return s;
  endfunction

  task automatic flush();
    res_q.delete(); res_r_q.delete(); res_cyc_q.delete(); hs_cyc_q.delete();
  endtask

  // All drive tasks start and end just after a rising edge.
  task automatic write_w(input int addr, input int data, input bit exp_err);
    w_wr_en = 1'b1; w_wr_addr = 5'(addr); w_wr_data = 18'(data);
    @(posedge clk); #1 w_wr_en = 1'b0;
    @(negedge clk);
    check("w_wr_err", longint'(w_wr_err), longint'(exp_err));
    @(negedge clk);
    check("w_wr_err_one_cycle", longint'(w_wr_err), 0);
    if (!exp_err) w_model[addr] = data;
    @(posedge clk); #1;
  endtask

  task automatic send_pixel(input int p);
    int b = 0;
    in_valid = 1'b1; in_pixel = 18'(p);
    @(negedge clk);
    while (!in_ready && b < 200) begin @(negedge clk); b++; end
    check("in_ready_wait", longint'(in_ready), 1);
    @(posedge clk); #1 in_valid = 1'b0;
  endtask

  task automatic send_range(input int pix[N], input int lo, input int hi, input bit gaps);
    for (int i = lo; i <= hi; i++) begin
      send_pixel(pix[i]);
      if (gaps && ($urandom_range(3) == 0)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic wait_results(input int n);
    int b = 0;
    while (res_q.size() < n && b < 200) begin @(posedge clk); #1; b++; end
    check("result_count", res_q.size(), n);
  endtask

  task automatic wait_idle();
    int b = 0;
    @(negedge clk);
    while (busy && b < 200) begin @(negedge clk); b++; end
    check("idle_wait", longint'(busy), 0);
    @(posedge clk); #1;
  endtask

  task automatic load_ramp();
    for (int i = 0; i < N; i++) write_w(i, 26 - i, 1'b0);
  endtask

  int ones[N], ramp[N], negs[N], twos[N], fives[N], rnd[N];

  initial begin
    for (int i = 0; i < N; i++) begin
      ones[i] = 1; ramp[i] = i + 1; negs[i] = -1; twos[i] = 2; fives[i] = 5;
      w_model[i] = 0;
    end

    // Reset state
    #1 rst = 1'b0;
    #2;
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_out_activation", sx(out_activation), 0);
    check("rst_busy", longint'(busy), 0);
    check("rst_w_wr_err", longint'(w_wr_err), 0);
    check("rst_relu_out_activation", sx(out_activation_r), 0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;

    // Ramp weights, window of +1 with exact latency and single-cycle valid
    load_ramp();
    send_range(ones, 0, N - 1, 1'b0);
    @(negedge clk);
    check("latency_valid_low_at_1", longint'(out_valid), 0);
    @(negedge clk);
    check("latency_valid_high_at_2", longint'(out_valid), 1);
    check("ones_result", sx(out_activation), model(ones, 1'b0));
    check("relu_ones_result", sx(out_activation_r), model(ones, 1'b1));
    @(negedge clk);
    check("valid_one_cycle", longint'(out_valid), 0);
    @(posedge clk); #1;

    // Ramp pixels then -1 pixels back to back
    flush();
    send_range(ramp, 0, N - 1, 1'b0);
    send_range(negs, 0, N - 1, 1'b0);
    wait_results(2);
    check("ramp_result", res_q[0], 3276);
    check("neg_result", res_q[1], -351);
    check("relu_ramp_result", res_r_q[0], 3276);
    check("relu_neg_result", res_r_q[1], 0);
    check("hs_count", hs_cyc_q.size(), 2 * N);
    check("no_bubble", hs_cyc_q[2 * N - 1] - hs_cyc_q[0], 2 * N - 1);
    check("b2b_latency", res_cyc_q[1] - hs_cyc_q[2 * N - 1], 2);
    wait_idle();

    // Randomized weights and pixels with random input gaps
    for (int w = 0; w < 3; w++) begin
      logic signed [17:0] r;
      for (int i = 0; i < N; i++) begin
        r = 18'($urandom);
        write_w(i, int'(r), 1'b0);
      end
      for (int i = 0; i < N; i++) begin
        r = 18'($urandom);
        rnd[i] = int'(r);
      end
      flush();
      send_range(rnd, 0, N - 1, 1'b1);
      wait_results(1);
      check("rand_result", res_q[0], model(rnd, 1'b0));
      check("rand_relu_result", res_r_q[0], model(rnd, 1'b1));
      wait_idle();
    end

    // Backpressure: held output blocks input until accepted
    load_ramp();
    flush();
    out_ready = 1'b0;
    send_range(ones, 0, N - 1, 1'b0);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_out_valid_held", longint'(out_valid), 1);
      check("bp_value_held", sx(out_activation), 351);
      check("bp_in_ready_low", longint'(in_ready), 0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_released_valid", longint'(out_valid), 0);
    check("bp_released_in_ready", longint'(in_ready), 1);
    @(posedge clk); #1;
    send_range(twos, 0, N - 1, 1'b0);
    wait_results(2);
    check("bp_first_result", res_q[0], 351);
    check("bp_next_window", res_q[1], model(twos, 1'b0));
    wait_idle();

    // Weight write while busy is rejected; write while idle is used
    flush();
    send_range(ones, 0, 9, 1'b0);
    write_w(10, 1000, 1'b1);
    send_range(ones, 10, N - 1, 1'b0);
    wait_results(1);
    check("busy_write_ignored", res_q[0], 351);
    wait_idle();
    write_w(10, 1000, 1'b0);
    flush();
    send_range(ones, 0, N - 1, 1'b0);
    wait_results(1);
    check("idle_write_used", res_q[0], model(ones, 1'b0));
    wait_idle();

    // Asynchronous reset mid-window
    send_range(ones, 0, 12, 1'b0);
    check("pre_rst_busy", longint'(busy), 1);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_busy", longint'(busy), 0);
    check("mid_rst_out_activation", sx(out_activation), 0);
    check("mid_rst_out_valid", longint'(out_valid), 0);
    @(posedge clk); #1 rst = 1'b1;
    for (int i = 0; i < N; i++) w_model[i] = 0;
    flush();
    send_range(fives, 0, N - 1, 1'b0);
    wait_results(1);
    check("weights_zero_after_rst", res_q[0], model(fives, 1'b0));
    wait_idle();

    // Clear mid-window with a product still in flight
    load_ramp();
    flush();
    send_range(ones, 0, N - 1, 1'b0);
    wait_results(1);
    wait_idle();
    send_range(fives, 0, 12, 1'b0);
    clear = 1'b1;
    @(negedge clk);
    check("clear_in_ready_low", longint'(in_ready), 0);
    @(posedge clk); #1 clear = 1'b0;
    @(negedge clk);
    check("clear_busy_low", longint'(busy), 0);
    check("clear_keeps_output", sx(out_activation), 351);
    @(posedge clk); #1;
    flush();
    send_range(ones, 0, N - 1, 1'b0);
    wait_results(1);
    check("after_clear_result", res_q[0], 351);
    check("after_clear_count", res_q.size(), 1);
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_window_macc.md
Name: conv_window_macc

Overview:
Parametrised multiply-accumulate engine that computes one convolution output per K x K x C window of streamed pixels against an internally held, runtime-loadable weight set. Pixels arrive over a valid/ready stream in window order (row, col, channel; channel fastest). The block keeps its own tap counters and emits one signed activation per window on a valid/ready output. It is the building block replicated per filter in the convolution layer.

Parameters:
DATA_W, 18, pixel width (signed two's complement)
COEF_W, 18, weight width (signed)
ACC_W, 48, accumulator/output width
K, 3, filter height = width
C, 3, input channel depth
RELU, 0, 1 = clamp negative results to 0 at output
Constraint: K*K*C >= 2; ACC_W >= DATA_W+COEF_W+clog2(K*K*C)

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-low reset
clear  in  1  sync abort: discard partial window and in-flight products
w_wr_en  in  1  weight write strobe
w_wr_addr  in  clog2(K*K*C)  tap index = (row*K+col)*C+ch
w_wr_data  in  COEF_W  weight value
w_wr_err  out  1  one-cycle pulse: write rejected
in_valid  in  1  pixel valid
in_ready  out  1  pixel accepted when in_valid&in_ready
in_pixel  in  DATA_W  pixel value
out_valid  out  1  activation valid
out_ready  in  1  downstream accept
out_activation  out  ACC_W  window result
busy  out  1  partial window or products in flight

Behaviour:
- Reset (rst low, async): tap counter=0, pipeline valids=0, accumulator=0, out_valid=0, out_activation=0, w_wr_err=0, busy=0. Weights reset to 0.
- Tap counter 0..N-1, N=K*K*C; advances on each input handshake; wraps N-1 -> 0.
- Stage 1 (cycle of handshake+1): registered product = in_pixel * weight[tap]; first/last flags carried.
- Stage 2 (+2): first tap loads accumulator with product; other taps add. Full-precision sign extension to ACC_W; no saturation (width constraint guarantees no overflow).
- Last tap: result (with RELU applied if enabled) latched into output register; out_valid rises 2 cycles after the last-tap handshake.
- Output holds value and out_valid stable until out_valid&out_ready.
- in_ready = !(out_valid & !out_ready) & !clear. With N>=2, a subsequent window can never complete while the output register is occupied. Back-to-back windows run with zero bubbles when out_ready=1.
- Simultaneous output handshake and new result arrival: the new result replaces the output register; out_valid stays 1.
- Weight writes are accepted only when busy=0 and no input handshake occurs in the same cycle. Otherwise the write is ignored and w_wr_err pulses for 1 cycle. Accepted writes are visible to the next tap read.
- clear: counter=0, stage valids=0, accumulator=0. The output register and out_valid are preserved. in_ready=0 during clear.
- busy = (counter!=0) | stage1 valid | stage2 valid.

Decomposition:
- Package conv_pkg: width defaults, N_TAPS(K,C) function, clog2-based TAP_W constant, signed pixel/coef/acc typedefs, tap-index type.
- Sub-module conv_weight_bank: N-entry register file with one write port (en/addr/data) and one combinational read port indexed by the tap counter. The reject logic stays in the parent.

Test Plan:
- Default params; load weight[i]=26-i, i=0..26; stream 27 pixels of +1 with out_ready=1 -> out_activation=351 exactly 2 cycles after the last handshake; out_valid for 1 cycle.
- Same weights; pixels 1..27 in tap order -> 3276. Then pixels all -1 back-to-back with no idle cycle -> -351 (48'hFFFF_FFFF_FEA1); no bubble between windows.
- RELU=1 build, -1 pixels -> 0; +1 pixels -> 351.
- Backpressure: hold out_ready=0 for 5 cycles after a result -> in_ready=0, output value and out_valid stable; release -> handshake, in_ready=1 next cycle, next window correct.
- Write weight at tap 10 while busy -> w_wr_err pulse, weight unchanged, result still 351. Write when idle -> no error, new value used.
- Assert rst low after 13 taps -> all outputs 0 immediately. Assert clear after 13 taps instead -> restart; a fresh 27-tap window gives 351 with no residue.
